// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: logic/shift/move ALU plus iterative DIV/DIVU unit.
// Results go to EX/MEM, the EX forwarding path and the HI/LO write port.
module ex_stage #(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              flush_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stallreq_o
);

  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MFLO = 8'h12;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_MOVE  = 3'd3;

  localparam int CNT_W = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;

  logic              is_div;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;
  logic              fits;
  logic [4:0]        sa;
  logic [DATA_W-1:0] alu_res;

  assign is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign a_neg  = (aluop_i == OP_DIV) && reg1_i[DATA_W-1];
  assign b_neg  = (aluop_i == OP_DIV) && reg2_i[DATA_W-1];
  assign a_abs  = a_neg ? -reg1_i : reg1_i;
  assign b_abs  = b_neg ? -reg2_i : reg2_i;

  // Restoring step: the partial remainder can briefly need DATA_W+1 bits before the compare.
  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign fits    = shifted >= {1'b0, dvs_q};
  assign diff    = shifted[DATA_W-1:0] - dvs_q;

  assign sa = reg1_i[4:0];

  always_comb begin
    alu_res = '0;
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_OR:   alu_res = reg1_i | reg2_i;
          OP_AND:  alu_res = reg1_i & reg2_i;
          OP_XOR:  alu_res = reg1_i ^ reg2_i;
          OP_NOR:  alu_res = ~(reg1_i | reg2_i);
          default: alu_res = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  alu_res = reg2_i << sa;
          OP_SRL:  alu_res = reg2_i >> sa;
          OP_SRA:  alu_res = $unsigned($signed(reg2_i) >>> sa);
          default: alu_res = '0;
        endcase
      end
      SEL_MOVE: begin
        case (aluop_i)
          OP_MFHI: alu_res = hi_i;
          OP_MFLO: alu_res = lo_i;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      S_IDLE: begin
        if (is_div && !flush_i) begin
          cnt_d = '0;
          dvs_d = b_abs;
          if (reg2_i == '0) begin
            // Divide by zero: all-ones quotient, raw dividend as remainder, no sign fixup.
            quo_d     = '1;
            rem_d     = reg1_i;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = S_DONE;
          end else begin
            quo_d     = a_abs;
            rem_d     = '0;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            state_d   = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        rem_d = fits ? diff : shifted[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], fits};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      wdata_o    = alu_res;
      stallreq_o = is_div && (state_q != S_DONE) && !flush_i;
      if ((state_q == S_DONE) && is_div && !flush_i) begin
        whilo_o = 1'b1;
        hi_o    = neg_rem_q ? -rem_q : rem_q;
        lo_o    = neg_quo_q ? -quo_q : quo_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage with directed vectors.
module tb_ex_stage;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MFLO = 8'h12;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop_i = 8'h00;
  logic [2:0]  alusel_i = 3'd0;
  logic [31:0] reg1_i = 32'h0;
  logic [31:0] reg2_i = 32'h0;
  logic [4:0]  wd_i = 5'd0;
  logic        wreg_i = 1'b0;
  logic [31:0] hi_i = 32'hDEADBEEF;
  logic [31:0] lo_i = 32'h12345678;
  logic        flush_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .hi_i(hi_i), .lo_i(lo_i), .flush_i(flush_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] stalls;
  } div_exp_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic        stall;
  } comb_exp_t;

  div_exp_t  div_q[$];
  comb_exp_t comb_q[$];
  int        n_checks = 0;
  int        n_pass = 0;
  int        stall_run = 0;
  logic      comb_req = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a HI/LO write or a combinational sample is due.
  initial forever begin
    @(negedge clk);
    if (rst || flush_i) stall_run = 0;
    else if (stallreq_o) stall_run++;
    if (whilo_o) begin
      if (div_q.size() == 0) begin
        check("unexpected_whilo", 32'(whilo_o), 32'd0);
      end else begin
        div_exp_t de;
        de = div_q.pop_front();
        check("div_hi", hi_o, de.hi);
        check("div_lo", lo_o, de.lo);
        check("div_stall_cycles", 32'(stall_run), de.stalls);
      end
      stall_run = 0;
    end
    if (comb_req) begin
      if (comb_q.size() == 0) begin
        check("comb_queue_underflow", 32'd1, 32'd0);
      end else begin
        comb_exp_t ce;
        ce = comb_q.pop_front();
        check("wdata", wdata_o, ce.wdata);
        check("wd", 32'(wd_o), 32'(ce.wd));
        check("wreg", 32'(wreg_o), 32'(ce.wreg));
        check("stallreq", 32'(stallreq_o), 32'(ce.stall));
        check("whilo_idle", 32'(whilo_o), 32'd0);
        check("hi_idle", hi_o, 32'd0);
        check("lo_idle", lo_o, 32'd0);
      end
    end
  end

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    comb_req = 1'b0;
    flush_i  = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wd, input logic wr);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
    wd_i     = wd;
    wreg_i   = wr;
  endtask

  task automatic comb_op(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_wdata);
    begin_cycle();
    set_op(op, sel, a, b, 5'd7, 1'b1);
    comb_q.push_back('{wdata: exp_wdata, wd: 5'd7, wreg: 1'b1, stall: 1'b0});
    comb_req = 1'b1;
  endtask

  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int stalls);
    logic got;
    begin_cycle();
    set_op(op, 3'd0, a, b, 5'd0, 1'b0);
    div_q.push_back('{hi: exp_hi, lo: exp_lo, stalls: 32'(stalls)});
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (whilo_o) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("div_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: every output forced to 0 even with a live op on the inputs.
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_op(OP_OR, 3'd1, 32'hFFFF0000, 32'h0000FFFF, 5'd9, 1'b1);
    comb_q.push_back('{wdata: 32'h0, wd: 5'd0, wreg: 1'b0, stall: 1'b0});
    comb_req = 1'b1;

    begin_cycle();
    set_op(OP_NOR, 3'd1, 32'h0F0F0000, 32'h00FF00FF, 5'd5, 1'b1);
    comb_q.push_back('{wdata: 32'hF000FF00, wd: 5'd5, wreg: 1'b1, stall: 1'b0});
    comb_req = 1'b1;

    comb_op(OP_OR,   3'd1, 32'h0F0F0000, 32'h00FF00FF, 32'h0FFF00FF);
    comb_op(OP_AND,  3'd1, 32'h0F0F0000, 32'h00FF00FF, 32'h000F0000);
    comb_op(OP_XOR,  3'd1, 32'h0F0F0000, 32'h00FF00FF, 32'h0FF000FF);
    comb_op(8'h20,   3'd1, 32'h0F0F0000, 32'h00FF00FF, 32'h00000000);
    comb_op(OP_SRA,  3'd2, 32'd4,        32'h80000010, 32'hF8000001);
    comb_op(OP_SRL,  3'd2, 32'd4,        32'h80000010, 32'h08000001);
    comb_op(OP_SLL,  3'd2, 32'd0,        32'h80000010, 32'h80000010);
    comb_op(OP_SLL,  3'd2, 32'hFFFFFFE4, 32'h80000010, 32'h00000100);
    comb_op(OP_SRA,  3'd2, 32'd0,        32'h80000010, 32'h80000010);
    comb_op(OP_SRA,  3'd2, 32'd31,       32'h80000000, 32'hFFFFFFFF);
    comb_op(OP_MFHI, 3'd3, 32'h1,        32'h2,        32'hDEADBEEF);
    comb_op(OP_MFLO, 3'd3, 32'h1,        32'h2,        32'h12345678);
    comb_op(OP_OR,   3'd0, 32'h1,        32'h2,        32'h00000000);
    comb_op(OP_OR,   3'd5, 32'h1,        32'h2,        32'h00000000);

    do_div(OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       33);
    do_div(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    do_div(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
    do_div(OP_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33);
    do_div(OP_DIVU, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1);
    do_div(OP_DIV,  32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1);
    // Back-to-back: the second divide is issued on the cycle right after the first result.
    do_div(OP_DIVU, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 33);
    do_div(OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        33);

    comb_op(OP_XOR, 3'd1, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555);

    // Flush mid-divide; the FSM must already be idle for a div-by-zero on the next cycle.
    begin_cycle();
    set_op(OP_DIVU, 3'd0, 32'd100, 32'd7, 5'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    comb_q.push_back('{wdata: 32'h0, wd: 5'd0, wreg: 1'b0, stall: 1'b0});
    comb_req = 1'b1;
    do_div(OP_DIVU, 32'h55, 32'd0, 32'h55, 32'hFFFFFFFF, 1);

    // Reset mid-divide, then a full-latency divide.
    begin_cycle();
    set_op(OP_DIVU, 3'd0, 32'd100, 32'd7, 5'd3, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    comb_q.push_back('{wdata: 32'h0, wd: 5'd0, wreg: 1'b0, stall: 1'b0});
    comb_req = 1'b1;
    do_div(OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 33);

    begin_cycle();
    set_op(OP_NOP, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("div_queue_drained", 32'(div_q.size()), 32'd0);
    check("comb_queue_drained", 32'(comb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
